// File: rtl/phy_rx_deser_pkg.sv
// Shared types and constants for the phy_rx lane receiver (phy_rx_deser and its comma detector).
package phy_rx_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] COMMA_DEFAULT    = 8'hBC;
    localparam int                BC_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        ALIGNED = 2'd1,
        ACTIVE  = 2'd2
    } rx_state_e;

endpackage

// File: rtl/phy_rx_deser_if.sv
// Lane-side bundle of phy_rx_deser: serial input from phy_tx and the parallel byte outputs.
interface phy_rx_deser_if;
    import phy_rx_pkg::*;

    logic              serial_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              byte_stb;
    logic              active;

    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  byte_stb,
        input  active
    );

    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output byte_stb,
        output active
    );

endinterface

// File: rtl/phy_rx_comma_det.sv
// Serial shift register with a combinational look-ahead window (nxt) and comma match on that window.
module phy_rx_comma_det
    import phy_rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] nxt,
    output logic              comma_hit
);

    logic [BYTE_W-1:0] shift_q;

    // The window includes the bit being sampled now, so a byte is judged on its LSB edge.
    assign nxt       = {shift_q[BYTE_W-2:0], serial_in};
    assign comma_hit = (nxt == COMMA);

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            shift_q <= '0;
        end else begin
            shift_q <= nxt;
        end
    end

endmodule

// File: rtl/phy_rx_deser.sv
// phy_rx_deser: single-lane receiver that locks onto idle commas, then emits non-comma bytes.
// Define PHY_RX_DESER_RELOCK_EN to drop lock when commas repeatedly arrive off the byte boundary.
module phy_rx_deser
    import phy_rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA    = COMMA_DEFAULT,
    parameter int                BC_COUNT = BC_COUNT_DEFAULT
) (
    input logic           clk_8f,
    input logic           reset_L,
    phy_rx_deser_if.slave bus
);

    localparam logic [3:0] BC_LAST = 4'(BC_COUNT - 1);

    rx_state_e         state;
    rx_state_e         state_d;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_d;
    logic [3:0]        comma_cnt;
    logic [3:0]        comma_cnt_d;
    logic [BYTE_W-1:0] data_q;
    logic [BYTE_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic              stb_q;
    logic              stb_d;
    logic              active_q;
    logic              active_d;

    logic [BYTE_W-1:0] nxt;
    logic              comma_hit;
    logic              boundary;
    logic              last_comma;
    logic              relock_drop;

    phy_rx_comma_det #(
        .COMMA (COMMA)
    ) u_comma_det (
        .clk_8f    (clk_8f),
        .reset_L   (reset_L),
        .serial_in (bus.serial_in),
        .nxt       (nxt),
        .comma_hit (comma_hit)
    );

    assign boundary   = (bit_cnt == 3'd7);
    assign last_comma = (comma_cnt == BC_LAST);

`ifdef PHY_RX_DESER_RELOCK_EN
    logic       mis_flag;
    logic       mis_flag_d;
    logic [2:0] mis_off;
    logic [2:0] mis_off_d;

    // A second off-boundary comma at the same bit offset means the stream has slipped.
    assign relock_drop = (state == ACTIVE) && !boundary && comma_hit &&
                         mis_flag && (mis_off == bit_cnt);

    always_comb begin
        mis_flag_d = mis_flag;
        mis_off_d  = mis_off;
        if (state == ACTIVE) begin
            if (boundary) begin
                if (comma_hit) begin
                    mis_flag_d = 1'b0;
                end
            end else if (comma_hit) begin
                mis_flag_d = !relock_drop;
                mis_off_d  = bit_cnt;
            end else if (mis_flag && (mis_off == bit_cnt)) begin
                // Expected repeat 8 cycles later did not arrive; forget the candidate.
                mis_flag_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            mis_flag <= 1'b0;
            mis_off  <= '0;
        end else begin
            mis_flag <= mis_flag_d;
            mis_off  <= mis_off_d;
        end
    end
`else
    assign relock_drop = 1'b0;
`endif

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state     <= INIT;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            stb_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            comma_cnt <= comma_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            stb_q     <= stb_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            INIT: begin
                if (comma_hit) begin
                    state_d = ALIGNED;
                end
            end
            ALIGNED: begin
                if (boundary) begin
                    if (!comma_hit) begin
                        state_d = INIT;
                    end else if (last_comma) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (relock_drop) begin
                    state_d = INIT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt + 3'd1;
        comma_cnt_d = comma_cnt;
        data_d      = data_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;
        active_d    = active_q;
        unique case (state)
            INIT: begin
                // First comma fixes the byte phase; bit_cnt restarts on the following bit.
                if (comma_hit) begin
                    bit_cnt_d   = '0;
                    comma_cnt_d = 4'd1;
                    stb_d       = 1'b1;
                end
            end
            ALIGNED: begin
                if (boundary) begin
                    if (comma_hit) begin
                        stb_d       = 1'b1;
                        comma_cnt_d = comma_cnt + 4'd1;
                        if (last_comma) begin
                            active_d = 1'b1;
                        end
                    end else begin
                        comma_cnt_d = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    stb_d = 1'b1;
                    if (comma_hit) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = nxt;
                        valid_d = 1'b1;
                    end
                end else if (relock_drop) begin
                    active_d    = 1'b0;
                    valid_d     = 1'b0;
                    comma_cnt_d = '0;
                end
            end
            default: begin
                comma_cnt_d = '0;
                active_d    = 1'b0;
                valid_d     = 1'b0;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.byte_stb  = stb_q;
    assign bus.active    = active_q;

endmodule

// File: doc/phy_rx_deser.md
Name: phy_rx_deser

Overview:
- Single-lane serial-to-parallel receiver that consumes one tx_out_N stream of the phy_tx serializer.
- Finds the byte boundary by locking onto the idle comma, then declares the lane active.
- Emits parallel bytes with a valid flag; idle commas are stripped.
- Two instances, one per lane, sit in phy_rx, directly downstream of phy_tx.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol the serializer sends when it has no valid data.
- BC_COUNT, 4, consecutive boundary-aligned commas required before the lane goes active (legal range 2..15).

Ports:
- clk_8f  input  1  bit clock; one serial bit per rising edge.
- reset_L  input  1  synchronous, active-low reset, sampled on posedge clk_8f.
- serial_in  input  1  serial stream, MSB first, 8 bits per byte.
- data_out  output  8  last received non-comma byte; held between boundaries.
- valid_out  output  1  1 when data_out holds a data byte received at the most recent boundary.
- byte_stb  output  1  one-cycle pulse on each byte boundary while aligned or active.
- active  output  1  lane locked and passing data.

Behaviour:
- Clocking: single clock clk_8f, all flops on posedge.
- Reset: synchronous, active-low. While reset_L=0 on an edge:
  - state=INIT, shift_q=0, bit_cnt=0, comma_cnt=0.
  - data_out=8'h00, valid_out=0, byte_stb=0, active=0.
- Shift register: each cycle nxt={shift_q[6:0],serial_in}, and shift_q<=nxt. All comparisons below use nxt, so a byte is judged on the edge that samples its LSB.
- State INIT (bit_cnt ignored):
  - if nxt==COMMA: bit_cnt<=0, comma_cnt<=1, byte_stb<=1, goto ALIGNED.
  - otherwise stay.
- Boundary rule in ALIGNED/ACTIVE:
  - bit_cnt increments mod 8.
  - A boundary occurs when bit_cnt==7; byte_stb=1 on the following cycle only.
- State ALIGNED, at each boundary:
  - nxt==COMMA and comma_cnt+1==BC_COUNT: goto ACTIVE, active<=1.
  - nxt==COMMA otherwise: comma_cnt<=comma_cnt+1.
  - nxt!=COMMA: goto INIT, comma_cnt<=0, no byte_stb.
  - Non-boundary cycles: no action.
- State ACTIVE, at each boundary:
  - nxt==COMMA: valid_out<=0, data_out held.
  - nxt!=COMMA: data_out<=nxt, valid_out<=1.
  - Outputs are held for 8 cycles until the next boundary.
  - ACTIVE never falls back to ALIGNED; only reset (or the optional relock) leaves it.
- Latency: last bit sampled at edge N means data_out/valid_out/byte_stb are visible after edge N (one register stage).
- Byte value 8'hBC is never delivered as data.
- Reset mid-operation: takes priority over every transition; lock must be reacquired from scratch.
- comma_cnt saturates at BC_COUNT.

Optional Feature:
- Macro: PHY_RX_DESER_RELOCK_EN.
- Defined:
  - In ACTIVE, track nxt==COMMA on a non-boundary cycle (bit_cnt!=7) using a 3-bit offset register plus a misalign flag.
  - Two such commas exactly 8 cycles apart at the same offset force: goto INIT, active<=0, valid_out<=0.
  - Any boundary-aligned comma clears the flag.
- Undefined: misaligned commas are ignored; ACTIVE persists until reset.

Decomposition:
- Package phy_rx_pkg holds:
  - the state encoding INIT/ALIGNED/ACTIVE (2 bits);
  - COMMA_DEFAULT=8'hBC and BC_COUNT_DEFAULT=4;
  - BYTE_W=8.
- One natural sub-module: phy_rx_comma_det. It contains the shift register plus the nxt==COMMA compare and exports nxt and comma_hit.
- The FSM and counters stay in phy_rx_deser.

Test Plan:
- Reset hold 5 cycles with random serial_in → all outputs 0, state INIT; release → still inactive until the first comma.
- 3 junk bits, then BC,BC,BC,BC,01,02,03 MSB-first → active=1 after the 4th BC; data_out 01,02,03 with valid_out=1; byte_stb every 8 cycles.
- ACTIVE, stream 05,BC,06 → valid_out 1,0,1; data_out 05,05,06; no BC ever on data_out.
- BC,BC,BC,55,BC,BC,BC,BC,7A → returns to INIT at 55; active rises at the 8th byte; 7A delivered valid.
- Drive reset_L=0 for 1 cycle while ACTIVE mid-byte → active=0, valid_out=0 next cycle; needs 4 fresh BCs to relock.
- PHY_RX_DESER_RELOCK_EN: in ACTIVE, shift stream by 3 bits and send BC,BC → drop to INIT, then relock at the new offset after 4 BCs. Without the macro, active stays 1.
